// File: rtl/biquad8_coeff_loader.sv
// biquad8_coeff_loader: stages coefficients and plays them out as a shift burst followed by one update strobe
module biquad8_coeff_loader #(
   parameter int NCOEFF       = 2,
   parameter int ADRBITS      = 1,
   parameter int CWIDTH       = 18,
   parameter int UPDATE_DELAY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADRBITS-1:0] s_adr_i,
   input  logic [CWIDTH-1:0] s_dat_i,
   input  logic              s_wr_i,
   input  logic              commit_i,
   input  logic              clr_err_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              overrun_o,
   output logic [CWIDTH-1:0] coeff_dat_o,
   output logic              coeff_wr_o,
   output logic              coeff_update_o
);
   localparam int CNTW = (ADRBITS > 4) ? ADRBITS : 4;
   typedef enum logic [2:0] {IDLE, LOAD, WAIT, UPDATE, DONE} state_t;
   state_t            state_q, state_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [CWIDTH-1:0] stage_q [NCOEFF];
   logic [CWIDTH-1:0] stage_d [NCOEFF];
   logic [CWIDTH-1:0] work_q [NCOEFF];
   logic [CWIDTH-1:0] work_d [NCOEFF];
   logic              accept;
   logic              busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;
   logic              wr_q, wr_d, upd_q, upd_d;
   logic [CWIDTH-1:0] dat_q, dat_d;
   // staging writes are merged before the snapshot so a same-cycle write wins
   always_comb begin
      accept  = commit_i && !busy_q;
      stage_d = stage_q;
      for (int i = 0; i < NCOEFF; i++)
         if (s_wr_i && s_adr_i == ADRBITS'(i)) stage_d[i] = s_dat_i;
      work_d = work_q;
      if (accept) work_d = stage_d;
   end
   // next state and next-cycle outputs, so every output leaves a flop
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = accept ? LOAD : IDLE;
            cnt_d   = CNTW'(NCOEFF - 1);
         end
         LOAD: begin
            state_d = (cnt_q == '0) ? WAIT : LOAD;
            cnt_d   = (cnt_q == '0) ? CNTW'(UPDATE_DELAY - 1) : cnt_q - CNTW'(1);
         end
         WAIT: begin
            state_d = (cnt_q == '0) ? UPDATE : WAIT;
            cnt_d   = cnt_q - CNTW'(1);
         end
         UPDATE: state_d = DONE;
         default: state_d = IDLE;
      endcase
      wr_d   = state_d == LOAD;
      upd_d  = state_d == UPDATE;
      done_d = state_d == DONE;
      busy_d = state_d inside {LOAD, WAIT, UPDATE};
      dat_d  = '0;
      for (int i = 0; i < NCOEFF; i++)
         if (wr_d && cnt_d == CNTW'(i)) dat_d = work_d[i];
      overrun_d = (commit_i && busy_q) || (overrun_q && !clr_err_i);
   end
   // state, buffers and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         stage_q   <= '{default: '0};
         work_q    <= '{default: '0};
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         wr_q      <= 1'b0;
         upd_q     <= 1'b0;
         dat_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         stage_q   <= stage_d;
         work_q    <= work_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
         wr_q      <= wr_d;
         upd_q     <= upd_d;
         dat_q     <= dat_d;
      end
   end
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign overrun_o      = overrun_q;
   assign coeff_dat_o    = dat_q;
   assign coeff_wr_o     = wr_q;
   assign coeff_update_o = upd_q;
endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// tb_biquad8_coeff_loader: table vectors plus corner sequences, strobe data checked through scoreboard queues
module tb_biquad8_coeff_loader;
   logic clk = 0, rst = 1;
   logic [0:0]  a_adr = '0;
   logic [17:0] a_dat = '0;
   logic a_wr = 0, a_commit = 0, a_clr = 0;
   logic a_busy, a_done, a_ovr, a_cwr, a_upd;
   logic [17:0] a_cdat;
   logic [2:0]  b_adr = '0;
   logic [17:0] b_dat = '0;
   logic b_wr = 0, b_commit = 0, b_clr = 0;
   logic b_busy, b_done, b_ovr, b_cwr, b_upd;
   logic [17:0] b_cdat;
   int n_chk = 0, n_err = 0, a_upd_cnt = 0;
   logic [17:0] qa[$], qb[$];
   logic [17:0] ma [2] = '{default: '0};
   typedef struct { logic [17:0] c0, c1, e_first, e_second; } vec_t;
   vec_t tbl [4];

   always #5 clk = ~clk;

   biquad8_coeff_loader dut_a (
      .clk(clk), .rst(rst), .s_adr_i(a_adr), .s_dat_i(a_dat), .s_wr_i(a_wr),
      .commit_i(a_commit), .clr_err_i(a_clr), .busy_o(a_busy), .done_o(a_done),
      .overrun_o(a_ovr), .coeff_dat_o(a_cdat), .coeff_wr_o(a_cwr), .coeff_update_o(a_upd));

   biquad8_coeff_loader #(.NCOEFF(4), .ADRBITS(3), .CWIDTH(18), .UPDATE_DELAY(1)) dut_b (
      .clk(clk), .rst(rst), .s_adr_i(b_adr), .s_dat_i(b_dat), .s_wr_i(b_wr),
      .commit_i(b_commit), .clr_err_i(b_clr), .busy_o(b_busy), .done_o(b_done),
      .overrun_o(b_ovr), .coeff_dat_o(b_cdat), .coeff_wr_o(b_cwr), .coeff_update_o(b_upd));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (a_cwr) begin
         if (qa.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL a_strobe_unexpected: got data %h expected no strobe", a_cdat);
         end else chk("a_data", 32'(a_cdat), 32'(qa.pop_front()));
      end else if (a_cdat != '0) chk("a_dat_idle", 32'(a_cdat), 0);
      if (b_cwr) begin
         if (qb.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL b_strobe_unexpected: got data %h expected no strobe", b_cdat);
         end else chk("b_data", 32'(b_cdat), 32'(qb.pop_front()));
      end else if (b_cdat != '0) chk("b_dat_idle", 32'(b_cdat), 0);
      if (a_upd) a_upd_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input bit b, input int adr, input logic [17:0] dat);
      if (b) begin b_wr = 1; b_adr = 3'(adr); b_dat = dat; end
      else begin
         a_wr = 1; a_adr = 1'(adr); a_dat = dat;
         if (adr < 2) ma[adr] = dat;
      end
      tick();
      a_wr = 0; b_wr = 0;
   endtask

   task automatic go(input bit b);
      if (b) b_commit = 1; else a_commit = 1;
      tick();
      a_commit = 0; b_commit = 0;
   endtask

   task automatic burst(input bit b, input int n, input int d, input bit chain);
      for (int t = 1; t <= n + d + 2; t++) begin
         chk(b ? "b_wr" : "a_wr", 32'(b ? b_cwr : a_cwr), 32'(t <= n));
         chk(b ? "b_update" : "a_update", 32'(b ? b_upd : a_upd), 32'(t == n + d + 1));
         chk(b ? "b_done" : "a_done", 32'(b ? b_done : a_done), 32'(t == n + d + 2));
         chk(b ? "b_busy" : "a_busy", 32'(b ? b_busy : a_busy), 32'(t <= n + d + 1));
         if (chain && t == n + d + 2) begin
            if (b) b_commit = 1; else a_commit = 1;
         end
         tick();
      end
      a_commit = 0; b_commit = 0;
   endtask

   task automatic wait_done(input bit b, input int max);
      bit seen = 0;
      for (int i = 0; i < max && !seen; i++) begin
         if (b ? b_done : a_done) seen = 1;
         else tick();
      end
      chk(b ? "b_done_seen" : "a_done_seen", 32'(seen), 1);
      tick();
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{18'h00123, 18'h3FFFF, 18'h3FFFF, 18'h00123};
      tbl[1] = '{18'h2AAAA, 18'h15555, 18'h15555, 18'h2AAAA};
      tbl[2] = '{18'h00000, 18'h20000, 18'h20000, 18'h00000};
      tbl[3] = '{18'h1FFFF, 18'h00001, 18'h00001, 18'h1FFFF};
      tick();
      tick();
      chk("rst_busy", 32'(a_busy), 0);
      chk("rst_wr", 32'(a_cwr), 0);
      chk("rst_outs", 32'({a_done, a_ovr, a_upd, b_busy, b_done, b_ovr, b_cwr, b_upd}), 0);
      rst = 0;
      tick();
      for (int v = 0; v < 4; v++) begin
         wr(0, 0, tbl[v].c0);
         wr(0, 1, tbl[v].c1);
         qa.push_back(tbl[v].e_first);
         qa.push_back(tbl[v].e_second);
         go(0);
         burst(0, 2, 2, 0);
         tick();
      end
      // write during a burst leaves the burst alone, shows up in the next one
      qa.push_back(ma[1]); qa.push_back(ma[0]);
      go(0);
      tick();
      wr(0, 0, 18'h00555);
      wait_done(0, 12);
      qa.push_back(ma[1]); qa.push_back(18'h00555);
      go(0);
      burst(0, 2, 2, 0);
      // write and commit in the same cycle: the write is in the snapshot
      a_wr = 1; a_adr = 1'b1; a_dat = 18'h2AAAA; ma[1] = 18'h2AAAA; a_commit = 1;
      qa.push_back(18'h2AAAA); qa.push_back(ma[0]);
      tick();
      a_wr = 0; a_commit = 0;
      burst(0, 2, 2, 0);
      // overrun: commit at k+3 dropped, flag from k+4, sticky until cleared
      qa.push_back(ma[1]); qa.push_back(ma[0]);
      go(0);
      chk("ovr_before", 32'(a_ovr), 0);
      tick();
      a_commit = 1;
      tick();
      a_commit = 0;
      chk("ovr_set", 32'(a_ovr), 1);
      wait_done(0, 12);
      chk("ovr_sticky", 32'(a_ovr), 1);
      a_clr = 1;
      tick();
      a_clr = 0;
      chk("ovr_cleared", 32'(a_ovr), 0);
      // clear and dropped commit together: set wins
      qa.push_back(ma[1]); qa.push_back(ma[0]);
      go(0);
      a_commit = 1; a_clr = 1;
      tick();
      a_commit = 0; a_clr = 0;
      chk("ovr_set_wins", 32'(a_ovr), 1);
      wait_done(0, 12);
      a_clr = 1;
      tick();
      a_clr = 0;
      chk("ovr_cleared2", 32'(a_ovr), 0);
      // back-to-back bursts with commit on the done cycle
      qa.push_back(ma[1]); qa.push_back(ma[0]);
      qa.push_back(ma[1]); qa.push_back(ma[0]);
      go(0);
      burst(0, 2, 2, 1);
      burst(0, 2, 2, 0);
      // four-coefficient instance, out-of-range writes ignored
      wr(1, 0, 18'd1);
      wr(1, 1, 18'd2);
      wr(1, 2, 18'd3);
      wr(1, 3, 18'd4);
      wr(1, 4, 18'h3FFFF);
      wr(1, 7, 18'h3FFFF);
      qb.push_back(18'd4); qb.push_back(18'd3); qb.push_back(18'd2); qb.push_back(18'd1);
      go(1);
      burst(1, 4, 1, 0);
      wr(1, 2, 18'h2AAAA);
      wr(1, 5, 18'h11111);
      qb.push_back(18'd4); qb.push_back(18'h2AAAA); qb.push_back(18'd2); qb.push_back(18'd1);
      qb.push_back(18'd4); qb.push_back(18'h2AAAA); qb.push_back(18'd2); qb.push_back(18'd1);
      go(1);
      burst(1, 4, 1, 1);
      burst(1, 4, 1, 0);
      // reset mid-burst: outputs drop at once, no update ever follows
      qa.push_back(ma[1]); qa.push_back(ma[0]);
      go(0);
      rst = 1;
      tick();
      chk("mid_rst_outs", 32'({a_busy, a_done, a_ovr, a_cwr, a_upd}), 0);
      chk("mid_rst_dat", 32'(a_cdat), 0);
      rst = 0;
      qa.delete();
      ma = '{default: '0};
      a_upd_cnt = 0;
      repeat (10) tick();
      chk("no_update_after_rst", 32'(a_upd_cnt), 0);
      qa.push_back(18'h0); qa.push_back(18'h0);
      go(0);
      burst(0, 2, 2, 0);
      qb.push_back(18'h0); qb.push_back(18'h0); qb.push_back(18'h0); qb.push_back(18'h0);
      go(1);
      burst(1, 4, 1, 0);
      tick();
      chk("qa_drained", 32'(qa.size()), 0);
      chk("qb_drained", 32'(qb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
